mdu_hilo: RTL and testbench
===========================

# mdu_hilo

Multiply/divide unit with the architectural HI/LO registers, located in the E stage of the five-stage MIPS pipeline. It consumes the decoded `start` and `HILO_Op` produced for the instruction entering E, runs multi-cycle multiply/divide operations, and serves MFHI/MFLO reads. It reports `HILO_busy` back to the stall logic, which holds later HI/LO instructions in D.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.
- `clk` input 1: single clock, all state updates on the rising edge.
- `reset` input 1: synchronous, active-low; `reset==0` at a rising edge clears all state.
- `start` input 1: pulse, high for exactly one cycle while a MULT/MULTU/DIV/DIVU is in E.
- `HILO_Op` input 4: operation code. 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO. Codes 9–15 behave as NONE.
- `A` input 32: rs operand, forwarded in E.
- `B` input 32: rt operand, forwarded in E.
- `Req` input 1: exception/interrupt flush. When high, the instruction currently in E is cancelled.
- `HILO_busy` output 1: high while an operation is in flight.
- `HILO_out` output 32: HI for MFHI, LO for MFLO, 0 otherwise.

## Operation
- State:
  - HI and LO, 32 bits each.
  - Result staging registers `hi_t` and `lo_t`.
  - Down-counter `cnt`, width sized for `DIV_CYCLES`.
- Arithmetic rules:
  - MULT: signed 32×32→64. HI = product[63:32], LO = product[31:0].
  - MULTU: unsigned 32×32→64, same split as MULT.
  - DIV: LO = quotient truncated toward zero. HI = remainder, carrying the sign of the dividend `A`.
  - DIV special case: 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (B = 0, DIV or DIVU):
  - Busy sequence runs normally.
  - HI and LO stay unchanged at completion.
- Start rule: `start & Req==0 & cnt==0` with a mult/div op.
  - Result is computed from `A`/`B` at that edge and latched into the staging registers.
  - `cnt` is loaded with `MULT_CYCLES` or `DIV_CYCLES`.
- Each cycle with `cnt != 0`, `cnt` decrements. When `cnt==1`, the same edge commits the staging registers into HI/LO.
- `HILO_busy = (cnt != 0)`, registered. The stall logic ORs in `start` itself, so no extra gating is needed here.
- MTHI/MTLO: when `cnt==0` and `Req==0`, HI (MTHI) or LO (MTLO) ← `A` at the edge.
- MFHI/MFLO: `HILO_out` is a combinational read of the current HI/LO.
- `Req`:
  - Blocks new starts and MTHI/MTLO in the same cycle.
  - Never aborts an operation already in flight, because that instruction has already left E and is committed.
- Ignored inputs:
  - `start` while `cnt != 0`; the stall logic guarantees this cannot happen.
  - `start` paired with a non-mult/div op.
  - MTHI/MTLO while `cnt != 0`.

## Timing
- Reset values: HI = 0, LO = 0, staging registers 0, `cnt` = 0, `HILO_busy` = 0, `HILO_out` = 0 for any MF op.
- Start accepted at edge E0, so `start` is high in cycle C0:
  - `HILO_busy` is high for cycles C1..CN, where N = `MULT_CYCLES` or `DIV_CYCLES`.
  - HI/LO update at the edge ending CN.
  - In cycle CN+1, `HILO_busy` = 0 and an MFHI/MFLO reads the new value.
- Back-to-back: a new `start` in CN+1 is accepted. There are no idle cycles between operations.
- MTHI/MTLO latency: 1 edge. An MFHI in the next cycle returns the written value.
- Reset mid-operation (`reset==0` at any edge): `cnt` → 0, `HILO_busy` → 0, HI/LO → 0. The pending result is discarded.
- `start` and `Req` in the same cycle: the start is dropped, `HILO_busy` stays 0, HI/LO are unchanged.
- `HILO_out` has zero latency (combinational from HI/LO and `HILO_Op`).

## Test plan
- Signed MULT: A = 0xFFFFFFFE (−2), B = 3, start pulse.
  - `HILO_busy` is high for exactly 5 cycles.
  - HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
  - An MFLO in the following cycle returns 0xFFFFFFFA.
- Unsigned MULTU: A = 0xFFFFFFFF, B = 2 → after 5 busy cycles, HI = 0x00000001, LO = 0xFFFFFFFE.
- Divide rules:
  - DIV A = −7 (0xFFFFFFF9), B = 2 → after 10 busy cycles, LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
  - DIVU by 0 with HI/LO preset → busy for 10 cycles, HI/LO unchanged.
- MTHI A = 0x12345678, then MFHI next cycle → `HILO_out` = 0x12345678.
- Flush cases:
  - `start` with `Req` = 1 → `HILO_busy` stays 0, HI/LO unchanged.
  - `Req` asserted at busy cycle 3 of a MULT → the operation completes and HI/LO update.
- Reset:
  - `reset` = 0 at busy cycle 4 of a DIV → next cycle `HILO_busy` = 0, HI = LO = 0.
  - A new MULT started right after reset completes normally in 5 cycles.

Source files
------------

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - E-stage multiply/divide unit with architectural HI/LO registers
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  HILO_Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    output logic        HILO_busy,
    output logic [31:0] HILO_out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   hi_t_q, hi_t_d, lo_t_q, lo_t_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    logic        is_mul, is_div, is_signed;
    logic [63:0] mul_a, mul_b, prod;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
    logic [31:0] res_hi, res_lo;

    assign is_mul    = (HILO_Op == OP_MULT) || (HILO_Op == OP_MULTU);
    assign is_div    = (HILO_Op == OP_DIV)  || (HILO_Op == OP_DIVU);
    assign is_signed = (HILO_Op == OP_MULT) || (HILO_Op == OP_DIV);

    // One 64-bit multiplier serves both MULT and MULTU via conditional sign extension.
    assign mul_a = {{32{is_signed & A[31]}}, A};
    assign mul_b = {{32{is_signed & B[31]}}, B};
    assign prod  = mul_a * mul_b;

    // Signed divide runs on magnitudes; 0x80000000/-1 falls out as 0x80000000 rem 0.
    assign a_mag  = (is_signed && A[31]) ? (~A + 32'd1) : A;
    assign b_mag  = (is_signed && B[31]) ? (~B + 32'd1) : B;
    assign b_safe = (B == 32'd0) ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quot   = (is_signed && (A[31] ^ B[31])) ? (~q_mag + 32'd1) : q_mag;
    assign rem    = (is_signed && A[31]) ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (is_div) begin
            if (B == 32'd0) begin
                // Divide by zero: stage the current HI/LO so the commit is a no-op.
                res_hi = hi_q;
                res_lo = lo_q;
            end else begin
                res_hi = rem;
                res_lo = quot;
            end
        end
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        hi_t_d = hi_t_q;
        lo_t_d = lo_t_q;
        cnt_d  = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                hi_d = hi_t_q;
                lo_d = lo_t_q;
            end
        end else if (!Req) begin
            if (start && (is_mul || is_div)) begin
                cnt_d  = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                hi_t_d = res_hi;
                lo_t_d = res_lo;
            end
            if (HILO_Op == OP_MTHI) hi_d = A;
            if (HILO_Op == OP_MTLO) lo_d = A;
        end
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            hi_t_q <= '0;
            lo_t_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            hi_t_q <= hi_t_d;
            lo_t_q <= lo_t_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign HILO_busy = busy_q;

    always_comb begin
        HILO_out = 32'd0;
        if (HILO_Op == OP_MFHI) HILO_out = hi_q;
        if (HILO_Op == OP_MFLO) HILO_out = lo_q;
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - directed self-checking bench for mdu_hilo
module tb_mdu_hilo;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  HILO_Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Req;
    logic        HILO_busy;
    logic [31:0] HILO_out;

    int tests_run = 0;
    int tests_failed = 0;

    mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .HILO_Op   (HILO_Op),
        .A         (A),
        .B         (B),
        .Req       (Req),
        .HILO_busy (HILO_busy),
        .HILO_out  (HILO_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        HILO_Op = 4'd5;
        #1 check({tag, " HI"}, HILO_out, exp_hi);
        HILO_Op = 4'd6;
        #1 check({tag, " LO"}, HILO_out, exp_lo);
        HILO_Op = 4'd0;
    endtask

    // Called in the low clock phase; issues the start and counts busy cycles at each negedge.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cyc, input int req_at,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        HILO_Op = op;
        A = a;
        B = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        HILO_Op = 4'd0;
        n = 0;
        while (HILO_busy && n < 40) begin
            n++;
            Req = (n == req_at);
            @(negedge clk);
        end
        Req = 1'b0;
        check({tag, " busy cycles"}, 32'(n), 32'(exp_cyc));
        read_hilo(tag, exp_hi, exp_lo);
    endtask

    task automatic move_to(input string tag, input logic [3:0] op, input logic [31:0] a, input logic req);
        HILO_Op = op;
        A = a;
        Req = req;
        @(negedge clk);
        HILO_Op = 4'd0;
        Req = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b0;
        start = 1'b0;
        HILO_Op = 4'd0;
        A = '0;
        B = '0;
        Req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("reset busy", 32'(HILO_busy), 32'd0);
        read_hilo("reset", 32'h0, 32'h0);
        HILO_Op = 4'd0;
        #1 check("out NONE", HILO_out, 32'h0);

        run_op("MULT -2*3", 4'd1, 32'hFFFFFFFE, 32'd3, 5, 0, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("MULTU", 4'd2, 32'hFFFFFFFF, 32'd2, 5, 0, 32'h00000001, 32'hFFFFFFFE);
        run_op("DIV -7/2", 4'd3, 32'hFFFFFFF9, 32'd2, 10, 0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("DIV ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 0, 32'h0, 32'h80000000);
        run_op("DIV 7/-2", 4'd3, 32'd7, 32'hFFFFFFFE, 10, 0, 32'h1, 32'hFFFFFFFD);

        move_to("MTHI", 4'd7, 32'h12345678, 1'b0);
        move_to("MTLO", 4'd8, 32'hCAFEF00D, 1'b0);
        read_hilo("MTHI/MTLO", 32'h12345678, 32'hCAFEF00D);

        run_op("DIVU by 0", 4'd4, 32'd55, 32'd0, 10, 0, 32'h12345678, 32'hCAFEF00D);
        run_op("DIVU 100/7", 4'd4, 32'd100, 32'd7, 10, 0, 32'd2, 32'd14);

        // Start together with Req must be dropped.
        HILO_Op = 4'd1; A = 32'd5; B = 32'd5; start = 1'b1; Req = 1'b1;
        @(negedge clk);
        start = 1'b0; Req = 1'b0; HILO_Op = 4'd0;
        check("start+Req busy", 32'(HILO_busy), 32'd0);
        repeat (6) @(negedge clk);
        read_hilo("start+Req", 32'd2, 32'd14);

        // start with a non-mult/div op is ignored.
        HILO_Op = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0; HILO_Op = 4'd0;
        check("start MFHI busy", 32'(HILO_busy), 32'd0);

        move_to("MTHI+Req", 4'd7, 32'hDEADBEEF, 1'b1);
        read_hilo("MTHI+Req", 32'd2, 32'd14);

        run_op("MULT Req@3", 4'd1, 32'h00010000, 32'h00010000, 5, 3, 32'h1, 32'h0);

        // MTLO while busy is ignored; the MULT result lands.
        HILO_Op = 4'd2; A = 32'd3; B = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        move_to("MTLO busy", 4'd8, 32'h55555555, 1'b0);
        n = 0;
        while (HILO_busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        read_hilo("MTLO busy", 32'h0, 32'd9);

        // Reset during the fourth busy cycle of a DIV.
        HILO_Op = 4'd3; A = 32'd100; B = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; HILO_Op = 4'd0;
        n = 1;
        while (n < 4) begin
            n++;
            @(negedge clk);
        end
        check("pre-reset busy", 32'(HILO_busy), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("mid-reset busy", 32'(HILO_busy), 32'd0);
        read_hilo("mid-reset", 32'h0, 32'h0);

        run_op("MULT after reset", 4'd1, 32'd7, 32'd6, 5, 0, 32'h0, 32'd42);
        run_op("MULT b2b", 4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 0, 32'h0, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
